// File: rtl/dmem_stage_pkg.sv
// Shared definitions for the data-memory / writeback stage.
//   - MIPS opcode and funct constants for the loads, stores and links the stage decodes
//   - access width encoding (SZ_BYTE / SZ_HALF / SZ_WORD)
//   - FSM state type and decoded-instruction struct
//   - helpers: instruction decode, big-endian byte enables, load lane extract/extend
package dmem_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_link;
    logic       sgn;      // sign-extend on load
    logic [1:0] sz;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d = '0;
    d.sz = SZ_WORD;
    case (ins[31:26])
      OP_LB:  begin d.is_load = 1'b1; d.sz = SZ_BYTE; d.sgn = 1'b1; end
      OP_LBU: begin d.is_load = 1'b1; d.sz = SZ_BYTE; end
      OP_LH:  begin d.is_load = 1'b1; d.sz = SZ_HALF; d.sgn = 1'b1; end
      OP_LHU: begin d.is_load = 1'b1; d.sz = SZ_HALF; end
      OP_LW:  begin d.is_load = 1'b1; d.sz = SZ_WORD; end
      OP_SB:  begin d.is_store = 1'b1; d.sz = SZ_BYTE; end
      OP_SH:  begin d.is_store = 1'b1; d.sz = SZ_HALF; end
      OP_SW:  begin d.is_store = 1'b1; d.sz = SZ_WORD; end
      OP_JAL: d.is_link = 1'b1;
      OP_SPECIAL: d.is_link = (ins[5:0] == FN_JALR);
      default: ;
    endcase
    return d;
  endfunction

  // Big-endian: lane 0 is bits [31:24], i.e. byte-enable bit 3.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b1000 >> lane;
      SZ_HALF: be = lane[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {~lane, 3'b000});
    h = lane[1] ? word[15:0] : word[31:16];
    case (sz)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Data memory array: DEPTH x 32-bit words.
//   CLK   in  clock; writes on rising edge
//   we    in  write enable
//   be    in  byte enables, be[3] = bits [31:24]
//   addr  in  word index (shared by read and write)
//   wdata in  write data, already placed on its byte lanes
//   rdata out combinational read of mem[addr]
// Contents start at INIT_VAL and are not affected by reset.
module dmem_ram #(
  parameter int          DEPTH    = 64,
  parameter int          ADDR_W   = $clog2(DEPTH),
  parameter logic [31:0] INIT_VAL = 32'd777
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH] = '{default: INIT_VAL};

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_stage.sv
// Data-memory / writeback stage.
//   CLK, RST   clock (rising edge), asynchronous active-low reset
//   valid      instruction present; Ins/Result/Rdata2/nextPC describe it
//   Wdata      registered writeback value, wb_valid pulses one cycle per instruction
//   stall      high while a wait-stated access is in progress
//   misalign   / oob flag the completing access, only meaningful with wb_valid
//   dbg_state  current FSM state
// Handshake: an instruction is taken at a rising edge when valid=1 and stall=0;
// while stall=1 valid is ignored and upstream must hold its inputs.
module dmem_stage
  import dmem_stage_pkg::*;
#(
  parameter int          DMEM_DEPTH  = 64,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] INIT_VAL    = 32'd777
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  input  logic [31:0] nextPC,
  output logic [31:0] Wdata,
  output logic        wb_valid,
  output logic        stall,
  output logic        misalign,
  output logic        oob,
  output state_t      dbg_state
);

  localparam int ADDR_W = $clog2(DMEM_DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef struct packed {
    dec_t              dec;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] widx;
    logic [31:0]       sdata;
    logic [31:0]       result;
  } acc_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  acc_t        lat_q, lat_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        mis_q, mis_d;
  logic        oob_q, oob_d;

  acc_t        in_acc, acc;
  logic        mis_in, oob_in, mem_in, accept, go_busy, access_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata, load_val;

  always_comb begin
    in_acc        = '0;
    in_acc.dec    = decode(Ins);
    in_acc.lane   = Result[1:0];
    in_acc.widx   = Result[ADDR_W+1:2];
    in_acc.sdata  = Rdata2;
    in_acc.result = Result;
  end

  assign oob_in = |Result[31:ADDR_W+2];
  assign mis_in = ((in_acc.dec.sz == SZ_WORD) && (in_acc.lane != 2'b00)) ||
                  ((in_acc.dec.sz == SZ_HALF) && in_acc.lane[0]);
  assign mem_in = in_acc.dec.is_load | in_acc.dec.is_store;
  assign accept = (state_q == S_IDLE) && valid;
  // Only clean memory ops pay wait states; faulted ops finish at once.
  assign go_busy = accept && mem_in && !mis_in && !oob_in && (WAIT_CYCLES > 0);

  // Memory is driven from the live inputs for a zero-wait access and from
  // the latched request while BUSY.
  assign acc = (state_q == S_BUSY) ? lat_q : in_acc;
  assign access_en = (accept && mem_in && !mis_in && !oob_in && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_BUSY) && (cnt_q == 4'd0));

  assign ram_we = access_en && acc.dec.is_store;
  assign ram_be = byte_en(acc.dec.sz, acc.lane);

  always_comb begin
    case (acc.dec.sz)
      SZ_BYTE: ram_wdata = {4{acc.sdata[7:0]}};
      SZ_HALF: ram_wdata = {2{acc.sdata[15:0]}};
      default: ram_wdata = acc.sdata;
    endcase
  end

  dmem_ram #(
    .DEPTH    (DMEM_DEPTH),
    .ADDR_W   (ADDR_W),
    .INIT_VAL (INIT_VAL)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (acc.widx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign load_val = load_extend(ram_rdata, acc.dec.sz, acc.lane, acc.dec.sgn);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    mis_d      = 1'b0;
    oob_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_busy) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
          lat_d   = in_acc;
        end else if (accept) begin
          wb_valid_d = 1'b1;
          mis_d      = mis_in && mem_in;
          oob_d      = oob_in && mem_in;
          if (in_acc.dec.is_load)      wdata_d = (mis_in || oob_in) ? 32'd0 : load_val;
          else if (in_acc.dec.is_link) wdata_d = nextPC;
          else                         wdata_d = Result;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wdata_d    = lat_q.dec.is_load ? load_val : lat_q.result;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      lat_q      <= '0;
      wdata_q    <= 32'd0;
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      mis_q      <= mis_d;
      oob_q      <= oob_d;
    end
  end

  assign Wdata     = wdata_q;
  assign wb_valid  = wb_valid_q;
  assign stall     = (state_q == S_BUSY);
  assign misalign  = mis_q;
  assign oob       = oob_q;
  assign dbg_state = state_q;

endmodule
